// File: rtl/mtow_stage.sv
// mtow_stage: pipeline register between the M (memory) and W (writeback)
// stages, plus the writeback-side decode that feeds the register file.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   stall, flush    hold W contents / load a bubble (flush wins over stall)
//   IR_M, PC_M, PC8_M, AO_M, DR_M, CP0_M, error_M   M-stage values
//   IR_W, PC_W, PC8_W, AO_W, error_W                 registered copies
//   DR_W            load data after byte/halfword extraction and extension
//   writereg_W      GRF destination register
//   writedata_W     GRF write data
//   regwrite_W      GRF write enable
//   tnew_W          always 0 (results are ready in W)
//   retired         count of non-bubble instructions accepted into W
module mtow_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] IR_M,
  input  logic [31:0] PC_M,
  input  logic [31:0] PC8_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] DR_M,
  input  logic [31:0] CP0_M,
  input  logic [3:0]  error_M,
  output logic [31:0] IR_W,
  output logic [31:0] PC_W,
  output logic [31:0] PC8_W,
  output logic [31:0] AO_W,
  output logic [3:0]  error_W,
  output logic [31:0] DR_W,
  output logic [4:0]  writereg_W,
  output logic [31:0] writedata_W,
  output logic        regwrite_W,
  output logic [3:0]  tnew_W,
  output logic [31:0] retired
);

  logic [31:0] ir_q, pc_q, pc8_q, ao_q, dr_q, cp0_q, retired_q;
  logic [3:0]  err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q      <= '0;
      pc_q      <= '0;
      pc8_q     <= '0;
      ao_q      <= '0;
      dr_q      <= '0;
      cp0_q     <= '0;
      err_q     <= '0;
      retired_q <= '0;
    end else if (flush) begin
      ir_q  <= '0;
      pc_q  <= '0;
      pc8_q <= '0;
      ao_q  <= '0;
      dr_q  <= '0;
      cp0_q <= '0;
      err_q <= '0;
    end else if (!stall) begin
      ir_q  <= IR_M;
      pc_q  <= PC_M;
      pc8_q <= PC8_M;
      ao_q  <= AO_M;
      dr_q  <= DR_M;
      cp0_q <= CP0_M;
      err_q <= error_M;
      if (IR_M != '0 && error_M == '0)
        retired_q <= retired_q + 32'd1;
    end
  end

  assign IR_W    = ir_q;
  assign PC_W    = pc_q;
  assign PC8_W   = pc8_q;
  assign AO_W    = ao_q;
  assign error_W = err_q;
  assign retired = retired_q;
  assign tnew_W  = '0;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        is_load, is_mfc0, is_jal, is_jalr, writes_grf;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];

  // Byte lane chosen by the low address bits; halfword ignores AO[0]
  // because misalignment has already been trapped in M.
  assign sel_byte = dr_q[{ao_q[1:0], 3'b000} +: 8];
  assign sel_half = ao_q[1] ? dr_q[31:16] : dr_q[15:0];

  always_comb begin
    is_load = 1'b0;
    DR_W    = dr_q;
    unique case (op)
      6'h23: is_load = 1'b1;
      6'h20: begin is_load = 1'b1; DR_W = {{24{sel_byte[7]}}, sel_byte}; end
      6'h24: begin is_load = 1'b1; DR_W = {24'h0, sel_byte}; end
      6'h21: begin is_load = 1'b1; DR_W = {{16{sel_half[15]}}, sel_half}; end
      6'h25: begin is_load = 1'b1; DR_W = {16'h0, sel_half}; end
      default: ;
    endcase
  end

  always_comb begin
    is_mfc0    = (op == 6'h10) && (rs == 5'h00);
    is_jal     = (op == 6'h03);
    is_jalr    = (op == 6'h00) && (funct == 6'h09);
    writereg_W = '0;
    writes_grf = 1'b0;
    if (op == 6'h00) begin
      writereg_W = rd;
      // jr, syscall, mthi, mtlo, mult, multu, div, divu leave the GRF alone
      unique case (funct)
        6'h08, 6'h0C, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: writes_grf = 1'b0;
        default: writes_grf = 1'b1;
      endcase
    end else if (is_jal) begin
      writereg_W = 5'd31;
      writes_grf = 1'b1;
    end else if (op[5:3] == 3'b001 || is_load || is_mfc0) begin
      writereg_W = rt;
      writes_grf = 1'b1;
    end
    regwrite_W = writes_grf && (writereg_W != '0) && (err_q == '0);
  end

  always_comb begin
    if (is_load)               writedata_W = DR_W;
    else if (is_jal || is_jalr) writedata_W = pc8_q;
    else if (is_mfc0)          writedata_W = cp0_q;
    else                       writedata_W = ao_q;
  end

endmodule
